// File: rtl/clock_gating_controller_pkg.sv
// Shared types and helpers for the clock-gating controller.
package clock_gating_controller_pkg;

    typedef enum logic [1:0] {
        GATED    = 2'd0,
        WAKING   = 2'd1,
        RUNNING  = 2'd2,
        COOLDOWN = 2'd3
    } clock_gating_state_t;

    // Width of a down-counter that must hold max(a, b); never narrower than 1 bit.
    function automatic int counter_width(input int a, input int b);
        int max_val;
        max_val = (a > b) ? a : b;
        return (max_val > 0) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/clock_gater.sv
// Latch-based clock gate: the enable is captured while the clock is low so the
// output can only start or stop on a full high phase, never mid-pulse.
module clock_gater (
    input  logic clock_in,
    input  logic enable,
    input  logic test_enable,
    output logic clock_out
);

    logic enable_latched;

    // Transparent while clock_in is low, holds through the high phase.
    always_latch begin
        if (!clock_in) begin
            enable_latched <= enable | test_enable;
        end
    end

    assign clock_out = clock_in & enable_latched;

endmodule

// File: rtl/clock_gating_controller.sv
// Sequences one clock_gater for several requesters: wake, settle, grant, and
// gate again after an idle cooldown.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// GATED    | gated clock stopped, waiting for any request or force_on
// WAKING   | gater enabled, counting settle cycles, no grants yet
// RUNNING  | clock guaranteed running, grants follow requests
// COOLDOWN | no demand, counting idle cycles before gating again
module clock_gating_controller
    import clock_gating_controller_pkg::*;
#(
    parameter int NUM_REQUESTERS = 4,
    parameter int WAKE_CYCLES    = 2,
    parameter int IDLE_CYCLES    = 16
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic [NUM_REQUESTERS-1:0] request,
    input  logic                      force_on,
    input  logic                      test_enable,
    output logic [NUM_REQUESTERS-1:0] grant,
    output logic                      clock_enabled,
    output logic                      gated_clock
);

    localparam int CW = counter_width(WAKE_CYCLES, IDLE_CYCLES);

    clock_gating_state_t state;
    clock_gating_state_t next_state;
    logic [CW-1:0]       count;
    logic [CW-1:0]       next_count;
    logic                any_req;

    assign any_req = (|request) | force_on;

    // State, counter and gater enable all move together on the rising edge.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state         <= GATED;
            count         <= '0;
            clock_enabled <= 1'b0;
        end else begin
            state         <= next_state;
            count         <= next_count;
            clock_enabled <= (next_state != GATED);
        end
    end

    // Next-state, counter reload/decrement, and grant qualification.
    always_comb begin
        next_state = state;
        next_count = count;
        grant      = '0;

        unique case (state)
            GATED: begin
                if (any_req) begin
                    if (WAKE_CYCLES == 0) begin
                        next_state = RUNNING;
                        next_count = '0;
                    end else begin
                        next_state = WAKING;
                        next_count = CW'(WAKE_CYCLES - 1);
                    end
                end
            end
            WAKING: begin
                // Wake always runs to completion, even if demand disappears.
                if (count == '0) begin
                    next_state = RUNNING;
                end else begin
                    next_count = count - CW'(1);
                end
            end
            RUNNING: begin
                grant = request;
                if (!any_req) begin
                    if (IDLE_CYCLES == 0) begin
                        next_state = GATED;
                        next_count = '0;
                    end else begin
                        next_state = COOLDOWN;
                        next_count = CW'(IDLE_CYCLES - 1);
                    end
                end
            end
            COOLDOWN: begin
                grant = request;
                // A request arriving on the expiry cycle still keeps the clock on.
                if (any_req) begin
                    next_state = RUNNING;
                    next_count = '0;
                end else if (count == '0) begin
                    next_state = GATED;
                end else begin
                    next_count = count - CW'(1);
                end
            end
            default: begin
                next_state = GATED;
                next_count = '0;
            end
        endcase
    end

    clock_gater u_clock_gater (
        .clock_in    (clock),
        .enable      (clock_enabled),
        .test_enable (test_enable),
        .clock_out   (gated_clock)
    );

endmodule

// File: tb/tb_clock_gating_controller.sv
// Scoreboard bench for clock_gating_controller: a timestamp/idle-run model
// predicts each edge's outputs; a monitor compares just after each edge.
module tb_clock_gating_controller;

    localparam int N = 4;
    localparam int W = 2;
    localparam int I = 16;

    logic         clock = 1'b0;
    logic         resetn = 1'b0;
    logic [N-1:0] request = '0;
    logic         force_on = 1'b0;
    logic         test_enable = 1'b0;
    logic [N-1:0] grant;
    logic         clock_enabled;
    logic         gated_clock;

    int n_cmp = 0;
    int n_err = 0;

    clock_gating_controller #(
        .NUM_REQUESTERS (N),
        .WAKE_CYCLES    (W),
        .IDLE_CYCLES    (I)
    ) dut (
        .clock         (clock),
        .resetn        (resetn),
        .request       (request),
        .force_on      (force_on),
        .test_enable   (test_enable),
        .grant         (grant),
        .clock_enabled (clock_enabled),
        .gated_clock   (gated_clock)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [N-1:0] grant;
        bit           en;
        bit           gclk;
        bit           chk_g;
    } exp_t;

    exp_t sb[$];

    // Reference model: enable is on from the waking edge; grants are allowed
    // from edge ok_at = wake edge + W; after that, a run of more than I
    // consecutive demand-free edges turns the clock off.
    int  cyc = 0;
    bit  m_en = 0;
    int  ok_at = 0;
    int  idle_run = 0;

    task automatic step(input bit rst, input logic [N-1:0] req, input bit fo, input bit te);
        exp_t e;
        bit   anyr;
        anyr = (|req) | fo;
        resetn = rst; request = req; force_on = fo; test_enable = te;
        e.gclk  = m_en | te;
        e.chk_g = (cyc >= 2);
        cyc++;
        if (!rst) begin
            m_en = 0;
            idle_run = 0;
        end else if (!m_en) begin
            if (anyr) begin
                m_en = 1;
                ok_at = cyc + W;
                idle_run = 0;
            end
        end else if (cyc > ok_at) begin
            idle_run = anyr ? 0 : idle_run + 1;
            if (idle_run > I) begin
                m_en = 0;
                idle_run = 0;
            end
        end
        e.en    = m_en;
        e.grant = (m_en && cyc >= ok_at) ? req : '0;
        sb.push_back(e);
        @(negedge clock);
    endtask

    task automatic hold(input bit rst, input logic [N-1:0] req, input bit fo, input bit te, input int n);
        for (int k = 0; k < n; k++) step(rst, req, fo, te);
    endtask

    // Monitor: compare just after each rising edge.
    int en_run = 0;
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                n_cmp++;
                if (grant !== e.grant) begin
                    n_err++;
                    $display("FAIL grant cyc=%0d got=%b exp=%b", n_cmp, grant, e.grant);
                end
                n_cmp++;
                if (clock_enabled !== e.en) begin
                    n_err++;
                    $display("FAIL clock_enabled t=%0t got=%b exp=%b", $time, clock_enabled, e.en);
                end
                if (e.chk_g) begin
                    n_cmp++;
                    if (gated_clock !== e.gclk) begin
                        n_err++;
                        $display("FAIL gated_high t=%0t got=%b exp=%b", $time, gated_clock, e.gclk);
                    end
                end
                if (grant != '0) begin
                    n_cmp++;
                    if (en_run < W) begin
                        n_err++;
                        $display("FAIL grant_prewake t=%0t got=%0d prior enabled cycles exp>=%0d", $time, en_run, W);
                    end
                end
                en_run = (clock_enabled === 1'b1) ? en_run + 1 : 0;
            end
        end
    end

    // Gated clock must be low throughout every low phase of the input clock.
    initial begin
        @(negedge clock);
        forever begin
            @(negedge clock);
            #1;
            n_cmp++;
            if (gated_clock !== 1'b0) begin
                n_err++;
                $display("FAIL gated_low t=%0t got=%b exp=0", $time, gated_clock);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t got=timeout exp=finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] r;
        bit fo, te, rst;
        // Reset with request[0] held, then release.
        hold(0, 4'b0001, 0, 0, 3);
        hold(1, 4'b0001, 0, 0, 6);
        hold(1, 4'b0000, 0, 0, 20);
        // request[1] pulse, full cooldown to gated.
        hold(1, 4'b0010, 0, 0, 5);
        hold(1, 4'b0000, 0, 0, 20);
        // Re-raise at cooldown cycle 10.
        hold(1, 4'b0010, 0, 0, 4);
        hold(1, 4'b0000, 0, 0, 10);
        hold(1, 4'b0010, 0, 0, 2);
        // Raise exactly on the expiry edge.
        hold(1, 4'b0000, 0, 0, I);
        hold(1, 4'b0100, 0, 0, 2);
        hold(1, 4'b0000, 0, 0, 20);
        // Request dropped during waking.
        hold(1, 4'b0100, 0, 0, 1);
        hold(1, 4'b0000, 0, 0, 22);
        // force_on alone, then test_enable while gated.
        hold(1, 4'b0000, 1, 0, 5);
        hold(1, 4'b0000, 0, 0, 20);
        hold(1, 4'b0000, 0, 1, 4);
        hold(1, 4'b0000, 0, 0, 2);
        // Reset asserted mid-cooldown and mid-wake.
        hold(1, 4'b1000, 0, 0, 4);
        hold(1, 4'b0000, 0, 0, 5);
        hold(0, 4'b0000, 0, 0, 2);
        hold(1, 4'b1000, 0, 0, 1);
        hold(0, 4'b1000, 0, 0, 2);
        hold(1, 4'b0000, 0, 0, 20);
        // Random traffic with sticky inputs.
        r = '0; fo = 0; te = 0;
        for (int k = 0; k < 1000; k++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(7) == 0) r[b] = ~r[b];
            if ($urandom_range(31) == 0) fo = ~fo;
            if ($urandom_range(31) == 0) te = ~te;
            rst = ($urandom_range(199) != 0);
            step(rst, r, fo, te);
        end
        hold(1, 4'b0000, 0, 0, 2);
        @(posedge clock);
        #2;
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain got=%0d pending exp=0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
